// File: rtl/dds_key_pkg.sv
// Shared types and default timing constants for the DDS pushbutton conditioner.
// The optional auto-repeat feature is selected with the DDS_KEY_AUTOREPEAT_EN macro.
package dds_key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  localparam int DEF_DEBOUNCE_CYCLES      = 1250000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 62500000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 12500000;

  // One shared width for every counter, sized from the largest timing parameter.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dds_key_debounce_fsm.sv
// Per-key synchronizer, debounce FSM and event generator.
// Auto-repeat counters exist only when DDS_KEY_AUTOREPEAT_EN is defined.
module dds_key_debounce_fsm
  import dds_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_event,
  output logic o_held
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DB_TERM = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  key_state_t    r_state;
  key_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_db_event;
  logic          w_rep_event;
  logic          r_held;
  logic          w_pressed;

  // The synchronizer stores the pressed level, so its reset value means released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_db_event  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pressed) begin
          w_state_nxt = PRESS_DB;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      PRESS_DB: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_db_event  = 1'b1;
        end else if (r_cnt != DB_TERM) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      HELD: begin
        if (!w_pressed) begin
          w_state_nxt = RELEASE_DB;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      RELEASE_DB: begin
        if (w_pressed) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != DB_TERM) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register; the held flag is registered from the next state so it tracks r_state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_held  <= (w_state_nxt == HELD) || (w_state_nxt == RELEASE_DB);
    end
  end

`ifdef DDS_KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_DELAY_LAST  = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] REP_PERIOD_LAST = CW'(REPEAT_PERIOD_CYCLES - 1);

  logic [CW-1:0] r_rcnt;
  logic          r_rphase;
  logic [CW-1:0] w_rep_last;

  assign w_rep_last  = r_rphase ? REP_PERIOD_LAST : REP_DELAY_LAST;
  assign w_rep_event = (r_state == HELD) && (r_rcnt == w_rep_last);

  // Repeat timer restarts whenever the key is not solidly held; first the delay, then the period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b0;
    end else if (r_state != HELD) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b0;
    end else if (w_rep_event) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b1;
    end else if (r_rcnt != '1) begin
      r_rcnt <= r_rcnt + CNT_ONE;
    end
  end
`else
  assign w_rep_event = 1'b0;
`endif

  assign o_event = w_db_event | w_rep_event;
  assign o_held  = r_held;

endmodule

// File: rtl/dds_key_conditioner.sv
// Two-key pushbutton conditioner producing single-cycle increase/decrease requests for the DDS.
// Define DDS_KEY_AUTOREPEAT_EN to enable auto-repeat while a key is held.
module dds_key_conditioner
  import dds_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key0_n,
  input  logic       i_key1_n,
  input  logic       i_enable,
  output logic       o_aumentar,
  output logic       o_disminuir,
  output logic [1:0] o_key_state
);

  logic w_ev0;
  logic w_ev1;
  logic w_held0;
  logic w_held1;
  logic r_aumentar;
  logic r_disminuir;

  dds_key_debounce_fsm #(
    .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
  ) u_key0 (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_key_n(i_key0_n),
    .o_event(w_ev0),
    .o_held (w_held0)
  );

  dds_key_debounce_fsm #(
    .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
  ) u_key1 (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_key_n(i_key1_n),
    .o_event(w_ev1),
    .o_held (w_held1)
  );

  // Arbitration: an event is dropped if the other key is down, both fire together, or gating is off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aumentar  <= 1'b0;
      r_disminuir <= 1'b0;
    end else begin
      r_aumentar  <= i_enable & w_ev0 & ~w_ev1 & ~w_held1;
      r_disminuir <= i_enable & w_ev1 & ~w_ev0 & ~w_held0;
    end
  end

  assign o_aumentar  = r_aumentar;
  assign o_disminuir = r_disminuir;
  assign o_key_state = {w_held1, w_held0};

endmodule
